// File: rtl/sha_pkg.sv
// sha_pkg: shared SHA-256 datapath widths and word types
package sha_pkg;
    localparam int WORD_W  = 32;
    localparam int DWORD_W = 64;
    typedef logic [DWORD_W-1:0] sha_dword_t;
endpackage

// File: rtl/sha_elastic_ptr.sv
// sha_elastic_ptr: wrapping pointer with increment enable and synchronous clear
module sha_elastic_ptr #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge CLK or posedge RST)
        if (RST) ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/sha_elastic_reg.sv
// sha_elastic_reg: DEPTH-entry elastic register slice with valid/ready on both sides
import sha_pkg::*;
module sha_elastic_reg #(
    parameter int DATA_W = DWORD_W,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic push, pop;
    assign full_o    = count == CNT_W'(DEPTH);
    assign empty_o   = count == '0;
    assign count_o   = count;
    assign in_ready  = ~full_o;
    assign out_valid = ~empty_o;
    // clr_i overrides both handshakes so a flush never moves data
    assign push      = in_valid & in_ready & ~clr_i;
    assign pop       = out_valid & out_ready & ~clr_i;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    sha_elastic_ptr #(.W(PTR_W)) u_wr (.CLK(CLK), .RST(RST), .clr(clr_i), .inc(push), .ptr(wr_ptr));
    sha_elastic_ptr #(.W(PTR_W)) u_rd (.CLK(CLK), .RST(RST), .clr(clr_i), .inc(pop), .ptr(rd_ptr));
    always_ff @(posedge CLK or posedge RST)
        if (RST) count <= '0;
        else count <= clr_i ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    always_ff @(posedge CLK or posedge RST)
        if (RST) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (push) mem[wr_ptr] <= in_data;
endmodule

// File: tb/tb_sha_elastic_reg.sv
// tb_sha_elastic_reg: directed checks of the elastic slice at DEPTH=2 and DEPTH=4
module tb_sha_elastic_reg;
    logic CLK = 0, RST = 0;
    always #5 CLK = ~CLK;
    logic c2, iv2, ir2, ov2, or2, f2, e2;
    logic [63:0] id2, od2;
    logic [1:0] n2;
    logic c4, iv4, ir4, ov4, or4, f4, e4;
    logic [63:0] id4, od4;
    logic [2:0] n4;
    int total = 0, bad = 0;
    sha_elastic_reg #(.DATA_W(64), .DEPTH(2)) d2 (
        .CLK(CLK), .RST(RST), .clr_i(c2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .count_o(n2), .full_o(f2), .empty_o(e2));
    sha_elastic_reg #(.DATA_W(64), .DEPTH(4)) d4 (
        .CLK(CLK), .RST(RST), .clr_i(c4), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .count_o(n4), .full_o(f4), .empty_o(e4));
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    initial begin
        int sent, got, mcnt;
        logic [63:0] nxt, exp_out;
        {c2, iv2, or2, c4, iv4, or4} = '0;
        id2 = '0;
        id4 = '0;
        // 1: asynchronous reset with no clock edge
        #2 RST = 1;
        #1;
        chk("rst_ov", 64'(ov2), 64'd0);
        chk("rst_od", od2, 64'd0);
        chk("rst_cnt", 64'(n2), 64'd0);
        chk("rst_empty", 64'(e2), 64'd1);
        chk("rst_full", 64'(f2), 64'd0);
        chk("rst_ir", 64'(ir2), 64'd1);
        chk("rst_cnt4", 64'(n4), 64'd0);
        #1 RST = 0;
        tick;
        // 2: fill DEPTH=2
        iv2 = 1;
        id2 = 64'h0123456789ABCDEF;
        tick;
        chk("fill1_cnt", 64'(n2), 64'd1);
        chk("fill1_od", od2, 64'h0123456789ABCDEF);
        id2 = 64'hFEDCBA9876543210;
        tick;
        chk("fill2_full", 64'(f2), 64'd1);
        chk("fill2_ir", 64'(ir2), 64'd0);
        chk("fill2_cnt", 64'(n2), 64'd2);
        chk("fill2_od", od2, 64'h0123456789ABCDEF);
        // 3: full with push and pop requested
        id2 = 64'h1;
        or2 = 1;
        tick;
        chk("fullpp_cnt", 64'(n2), 64'd1);
        chk("fullpp_od", od2, 64'hFEDCBA9876543210);
        chk("fullpp_ir", 64'(ir2), 64'd1);
        iv2 = 0;
        tick;
        chk("drain_cnt", 64'(n2), 64'd0);
        chk("drain_empty", 64'(e2), 64'd1);
        chk("drain_od", od2, 64'd0);
        tick;
        chk("emptypop_cnt", 64'(n2), 64'd0);
        or2 = 0;
        // 4: stream 1..10 through DEPTH=4 with toggling out_ready
        sent = 0;
        got = 0;
        mcnt = 0;
        nxt = 1;
        exp_out = 1;
        for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
            iv4 = sent < 10;
            id4 = nxt;
            or4 = cyc[0];
            if (iv4 && mcnt < 4) begin
                sent++;
                nxt++;
                mcnt++;
            end
            if (or4 && ov4) begin
                chk("stream_data", od4, exp_out);
                exp_out++;
                got++;
                mcnt--;
            end
            tick;
            chk("stream_cnt", 64'(n4), 64'(mcnt));
        end
        iv4 = 0;
        or4 = 0;
        chk("stream_got", 64'(got), 64'd10);
        chk("stream_empty", 64'(e4), 64'd1);
        // 5: flush beats simultaneous push and pop
        iv4 = 1;
        for (int i = 11; i <= 13; i++) begin
            id4 = 64'(i);
            tick;
        end
        chk("preclr_cnt", 64'(n4), 64'd3);
        chk("preclr_od", od4, 64'd11);
        c4 = 1;
        id4 = 64'd99;
        or4 = 1;
        tick;
        chk("clr_cnt", 64'(n4), 64'd0);
        chk("clr_empty", 64'(e4), 64'd1);
        chk("clr_od", od4, 64'd0);
        chk("clr_ov", 64'(ov4), 64'd0);
        {c4, iv4, or4} = '0;
        tick;
        chk("postclr_cnt", 64'(n4), 64'd0);
        // 6: count=1 with simultaneous push and pop
        iv4 = 1;
        id4 = 64'd20;
        tick;
        chk("pp_start_cnt", 64'(n4), 64'd1);
        or4 = 1;
        for (int i = 0; i < 8; i++) begin
            id4 = 64'(21 + i);
            chk("pp_od", od4, 64'(20 + i));
            tick;
            chk("pp_cnt", 64'(n4), 64'd1);
        end
        iv4 = 0;
        chk("pp_last", od4, 64'd28);
        tick;
        chk("pp_end_cnt", 64'(n4), 64'd0);
        or4 = 0;
        // reset in the middle of a transfer
        iv4 = 1;
        id4 = 64'd77;
        tick;
        chk("mid_cnt", 64'(n4), 64'd1);
        RST = 1;
        #1;
        chk("midrst_cnt", 64'(n4), 64'd0);
        chk("midrst_od", od4, 64'd0);
        chk("midrst_ir", 64'(ir4), 64'd1);
        #1 RST = 0;
        iv4 = 0;
        tick;
        chk("postrst_cnt", 64'(n4), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
